product_bcd_converter: RTL and testbench
========================================

Name: product_bcd_converter

Overview:
Downstream stage of the Booth multiplier top level. It captures the multiplier's Product when Ready rises and converts the signed two's-complement value to sign plus packed BCD magnitude. Conversion uses a sequential shift-and-add-3 (double-dabble) pass, one bit per clock. Results feed the board's seven-segment display driver.

Parameters:
WIDTH, 16, number of low Product bits treated as the signed two's-complement result.
DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^(WIDTH-1).
SIGNED, 1, 1 = Product[WIDTH-1] is the sign; 0 = value is unsigned and Sign is held 0.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
Reset  input  1  asynchronous, active-low reset.
Product  input  17  multiplier result; only bits [WIDTH-1:0] are used.
Ready  input  1  multiplier result-valid level; only its 0->1 transition is used.
Digits  output  4*DIGITS  packed BCD magnitude; digit 0 (ones) is in bits [3:0].
Sign  output  1  1 = negative result.
Busy  output  1  high while a conversion is in progress.
Valid  output  1  high when Digits/Sign hold a completed conversion.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; Digits=0, Sign=0, Busy=0, Valid=0; internal ready_q=0, counter=0, shift registers=0.
- Edge detect: ready_q registers Ready each cycle. A capture edge is a clock edge where Ready=1 and ready_q=0.
- States: IDLE, CONVERT, DONE.
- IDLE or DONE + capture edge -> CONVERT:
  - latch sign s = SIGNED & Product[WIDTH-1];
  - latch magnitude = s ? (~Product[WIDTH-1:0] + 1) : Product[WIDTH-1:0] as WIDTH-bit unsigned (0x8000 yields 32768);
  - clear BCD scratch; counter=0; Valid=0; Busy=1.
- CONVERT, each edge:
  - every scratch digit >= 5 gets +3;
  - then {scratch, magnitude} shifts left by 1;
  - counter increments.
- On the edge that completes iteration WIDTH: Digits<=scratch result, Sign<=s, state=DONE, Busy=0, Valid=1.
- Latency: Valid is high after exactly WIDTH+1 edges counted from and including the capture edge (17 for the default configuration).
- Capture edge during CONVERT: ignored, and that result is dropped. Because ready_q still tracks Ready, no delayed capture occurs.
- DONE: Digits/Sign/Valid hold until the next capture edge. The capture edge clears Valid; Digits/Sign keep their old values until the new completion.
- Ready held high: only one capture per rising transition.
- Zero magnitude with s=1 cannot occur; the value 0 always gives Sign=0.
- Reset asserted mid-CONVERT: immediate return to reset values; no partial result is published.
- Product bits above WIDTH-1 are ignored.

Decomposition:
- Shared package/include:
  - state encoding constants (IDLE=2'd0, CONVERT=2'd1, DONE=2'd2);
  - default DIGITS/WIDTH values;
  - BCD_ADJ_THRESHOLD=4'd5.
- One sub-module, bcd_digit_adj: combinational 4-bit in/out, adds 3 when input >= 5. Instantiated DIGITS times via generate.

Test Plan:
- Product=17'h0_04D2, Ready 0->1 -> after 17 edges Valid=1, Digits=20'h01234, Sign=0, Busy=1 during the 16 CONVERT cycles.
- Product=17'h0_FF85 (-123) -> Digits=20'h00123, Sign=1. Product=17'h0_0000 -> Digits=20'h00000, Sign=0.
- Boundaries: 17'h0_8000 -> Digits=20'h32768, Sign=1; 17'h0_7FFF -> Digits=20'h32767, Sign=0; 17'h1_0005 -> Digits=20'h00005 (bit 16 ignored).
- Start 1234, toggle Ready 0->1 with Product=-1 at iteration 5 -> result is still 01234/Sign=0, and no second conversion starts.
- In DONE with 01234, new Ready edge with Product=17'h0_0063 -> Valid drops the next cycle, Digits stays 01234 until completion, then 00099.
- Assert Reset at iteration 8 -> all outputs 0 asynchronously. Release Reset with Ready already high -> no capture until Ready falls and rises again.

Source files
------------

// File: rtl/product_bcd_converter_pkg.sv
// Shared definitions for the product-to-BCD display stage.
// State encoding, default geometry and the double-dabble adjust threshold.
package product_bcd_converter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_DIGITS = 5;

    localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd5;

endpackage

// File: rtl/product_bcd_converter_bcd_digit_adj.sv
// One BCD digit of the shift-and-add-3 step: adds 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import product_bcd_converter_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= BCD_ADJ_THRESHOLD) ? din + 4'd3 : din;

endmodule

// File: rtl/product_bcd_converter.sv
// Captures the multiplier Product on a rising Ready and converts it to sign plus
// packed BCD magnitude with a one-bit-per-clock double-dabble pass.
module product_bcd_converter
    import product_bcd_converter_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS,
    parameter bit SIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic [16:0]           Product,
    input  logic                  Ready,
    output logic [4*DIGITS-1:0]   Digits,
    output logic                  Sign,
    output logic                  Busy,
    output logic                  Valid
);

    localparam int BCDW = 4 * DIGITS;
    localparam int CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t            state_reg, state_next;
    logic              ready_q_reg;
    logic              armed_reg;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [BCDW-1:0]   scratch_reg, scratch_next;
    logic [WIDTH-1:0]  mag_reg, mag_next;
    logic              sign_s_reg, sign_s_next;
    logic [BCDW-1:0]   digits_reg, digits_next;
    logic              sign_reg, sign_next;

    logic [BCDW-1:0]   scratch_adj;
    logic [WIDTH-1:0]  prod_w;
    logic              capture;
    logic              unused_bits;

    assign prod_w = Product[WIDTH-1:0];
    // The top adjusted bit always shifts out as zero when DIGITS is sized correctly.
    assign unused_bits = ^{Product, scratch_adj[BCDW-1]};

    // armed_reg blocks a capture until Ready has been seen low after reset, so a
    // Ready that is already high when reset releases does not start a conversion.
    assign capture = Ready & ~ready_q_reg & armed_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (scratch_reg[4*gi +: 4]),
                .dout (scratch_adj[4*gi +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_reg   <= IDLE;
            ready_q_reg <= 1'b0;
            armed_reg   <= 1'b0;
            cnt_reg     <= '0;
            scratch_reg <= '0;
            mag_reg     <= '0;
            sign_s_reg  <= 1'b0;
            digits_reg  <= '0;
            sign_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ready_q_reg <= Ready;
            armed_reg   <= armed_reg | ~Ready;
            cnt_reg     <= cnt_next;
            scratch_reg <= scratch_next;
            mag_reg     <= mag_next;
            sign_s_reg  <= sign_s_next;
            digits_reg  <= digits_next;
            sign_reg    <= sign_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        scratch_next = scratch_reg;
        mag_next     = mag_reg;
        sign_s_next  = sign_s_reg;
        digits_next  = digits_reg;
        sign_next    = sign_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (capture) begin
                    state_next   = CONVERT;
                    sign_s_next  = SIGNED & prod_w[WIDTH-1];
                    mag_next     = sign_s_next ? (~prod_w) + WIDTH'(1) : prod_w;
                    scratch_next = '0;
                    cnt_next     = '0;
                end
            end
            CONVERT: begin
                // Captures arriving here are deliberately ignored.
                scratch_next = {scratch_adj[BCDW-2:0], mag_reg[WIDTH-1]};
                mag_next     = {mag_reg[WIDTH-2:0], 1'b0};
                cnt_next     = cnt_reg + CW'(1);
                if (cnt_reg == LAST_ITER) begin
                    state_next  = DONE;
                    digits_next = scratch_next;
                    sign_next   = sign_s_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign Busy   = (state_reg == CONVERT);
    assign Valid  = (state_reg == DONE);
    assign Digits = digits_reg;
    assign Sign   = sign_reg;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench: table-driven conversions through a scoreboard, plus
// sequences for ignored captures, recapture from DONE and reset mid-conversion.
module tb_product_bcd_converter;

    logic        clk = 1'b0;
    logic        Reset;
    logic [16:0] Product;
    logic        Ready;
    logic [19:0] Digits;
    logic        Sign;
    logic        Busy;
    logic        Valid;

    always #5 clk = ~clk;

    product_bcd_converter dut (
        .clk     (clk),
        .Reset   (Reset),
        .Product (Product),
        .Ready   (Ready),
        .Digits  (Digits),
        .Sign    (Sign),
        .Busy    (Busy),
        .Valid   (Valid)
    );

    typedef struct {
        logic [16:0] product;
        logic [19:0] digits;
        logic        sign;
    } vec_t;

    typedef struct {
        logic [19:0] digits;
        logic        sign;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic valid_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard pop on every rising Valid.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (Valid && !valid_prev) begin
            check("sb_empty_at_valid", 32'(sb.size() == 0), 0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                $display("txn: digits=%05h sign=%0b expected digits=%05h sign=%0b",
                         Digits, Sign, e.digits, e.sign);
                check("digits", 32'(Digits), 32'(e.digits));
                check("sign", 32'(Sign), 32'(e.sign));
            end
        end
        valid_prev = Valid;
    end

    task automatic run_vec(input logic [16:0] p, input logic [19:0] d, input logic s);
        int busy_bad;
        busy_bad = 0;
        sb.push_back('{d, s});
        Product = p;
        Ready   = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) Ready = 1'b0;
            if (k < 17 && (Busy !== 1'b1 || Valid !== 1'b0)) busy_bad++;
        end
        check("busy_window", 32'(busy_bad), 0);
        check("valid_at_17", 32'(Valid), 1);
        check("busy_at_17", 32'(Busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{17'h0_04D2, 20'h01234, 1'b0};
        vecs[1] = '{17'h0_FF85, 20'h00123, 1'b1};
        vecs[2] = '{17'h0_0000, 20'h00000, 1'b0};
        vecs[3] = '{17'h0_8000, 20'h32768, 1'b1};
        vecs[4] = '{17'h0_7FFF, 20'h32767, 1'b0};
        vecs[5] = '{17'h1_0005, 20'h00005, 1'b0};
        vecs[6] = '{17'h0_FFFF, 20'h00001, 1'b1};
        vecs[7] = '{17'h0_270F, 20'h09999, 1'b0};
        vecs[8] = '{17'h1_FFFE, 20'h00002, 1'b1};

        Reset   = 1'b0;
        Ready   = 1'b0;
        Product = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_digits", 32'(Digits), 0);
        check("reset_sign", 32'(Sign), 0);
        check("reset_busy", 32'(Busy), 0);
        check("reset_valid", 32'(Valid), 0);
        Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i].product, vecs[i].digits, vecs[i].sign);

        // Second Ready edge mid-conversion is dropped; holding Ready high does not retrigger.
        sb.push_back('{20'h01234, 1'b0});
        Product = 17'h0_04D2;
        Ready   = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) Ready = 1'b0;
            if (k == 5) begin
                Product = 17'h0_FFFF;
                Ready   = 1'b1;
            end
        end
        check("ignored_valid_at_17", 32'(Valid), 1);
        repeat (5) @(posedge clk);
        #1;
        check("no_recapture_busy", 32'(Busy), 0);
        check("no_recapture_valid", 32'(Valid), 1);
        check("no_recapture_digits", 32'(Digits), 32'h01234);
        Ready = 1'b0;
        @(posedge clk);
        #1;

        // Recapture from DONE: Valid drops, old digits held until completion.
        sb.push_back('{20'h00099, 1'b0});
        Product = 17'h0_0063;
        Ready   = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                Ready = 1'b0;
                check("recap_valid_drop", 32'(Valid), 0);
                check("recap_digits_hold_early", 32'(Digits), 32'h01234);
            end
            if (k == 10) check("recap_digits_hold_mid", 32'(Digits), 32'h01234);
        end
        check("recap_valid_at_17", 32'(Valid), 1);

        // Reset during iteration 8, released with Ready already high.
        Product = 17'h0_04D2;
        Ready   = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) Ready = 1'b0;
        end
        Ready = 1'b1;
        #2;
        Reset = 1'b0;
        #1;
        check("async_reset_digits", 32'(Digits), 0);
        check("async_reset_sign", 32'(Sign), 0);
        check("async_reset_busy", 32'(Busy), 0);
        check("async_reset_valid", 32'(Valid), 0);
        @(negedge clk);
        Reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_no_capture_busy", 32'(Busy), 0);
        check("post_reset_no_capture_valid", 32'(Valid), 0);
        Ready = 1'b0;
        @(posedge clk);
        #1;
        run_vec(17'h0_FF85, 20'h00123, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
